// File: rtl/latch_regfile.sv
// latch_regfile: register file with one edge-synchronous write port and NREAD combinational read ports.
// A staging register captured on rising CLK feeds word latches that are transparent while CLK is low.
module latch_regfile #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int NREAD    = 2,
    parameter bit ZERO_REG = 1,
    parameter bit BYPASS   = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   WE,
    input  logic [AW-1:0]          WADDR,
    input  logic [WIDTH-1:0]       WDATA,
    input  logic [NREAD*AW-1:0]    RADDR,
    output logic [NREAD*WIDTH-1:0] RDATA
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic             valid_q, valid_d;
    logic [AW-1:0]    waddr_q, waddr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             wr_ok;

    // Out-of-range and suppressed-zero writes never reach the staging register.
    always_comb begin
        wr_ok = 1'b0;
        for (int j = 0; j < DEPTH; j++)
            if (WADDR == AW'(j) && !(ZERO_REG && j == 0)) wr_ok = WE;
        valid_d = wr_ok;
        waddr_d = wr_ok ? WADDR : waddr_q;
        wdata_d = wr_ok ? WDATA : wdata_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            valid_q <= valid_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_latch begin
        if (RST) begin
            for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
        end else if (!CLK && valid_q) begin
            for (int j = 0; j < DEPTH; j++)
                if (waddr_q == AW'(j)) mem[j] <= wdata_q;
        end
    end

    // The staged word is forwarded during the high phase so the latch phase is never visible.
    always_comb begin
        RDATA = '0;
        for (int i = 0; i < NREAD; i++)
            for (int j = 0; j < DEPTH; j++)
                if (RADDR[i*AW +: AW] == AW'(j) && !(ZERO_REG && j == 0))
                    RDATA[i*WIDTH +: WIDTH] = (BYPASS && wr_ok && !RST && WADDR == AW'(j)) ? WDATA :
                                              (valid_q && waddr_q == AW'(j)) ? wdata_q : mem[j];
    end
endmodule

// File: tb/tb_latch_regfile.sv
// tb_latch_regfile: scoreboard bench over three configurations of latch_regfile.
// Stimulus queues expected read values; a monitor pops and compares them on each sample strobe.
module tb_latch_regfile;
    logic        clk, rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rd0, rd1;
    logic        we2;
    logic [3:0]  waddr2;
    logic [7:0]  wdata2;
    logic [11:0] raddr2;
    logic [23:0] rd2;

    typedef struct {
        string       name;
        int          dut;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;
    event go;

    latch_regfile u0 (.CLK(clk), .RST(rst), .WE(we), .WADDR(waddr), .WDATA(wdata), .RADDR(raddr), .RDATA(rd0));
    latch_regfile #(.ZERO_REG(0), .BYPASS(0)) u1 (.CLK(clk), .RST(rst), .WE(we), .WADDR(waddr), .WDATA(wdata), .RADDR(raddr), .RDATA(rd1));
    latch_regfile #(.WIDTH(8), .DEPTH(12), .NREAD(3)) u2 (.CLK(clk), .RST(rst), .WE(we2), .WADDR(waddr2), .WDATA(wdata2), .RADDR(raddr2), .RDATA(rd2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] actual(int dut, int port);
        case (dut)
            0:       return rd0[port*32 +: 32];
            1:       return rd1[port*32 +: 32];
            default: return {24'b0, rd2[port*8 +: 8]};
        endcase
    endfunction

    initial begin
        exp_t        x;
        logic [31:0] a;
        forever begin
            @(go);
            #1;
            while (q.size() > 0) begin
                x = q.pop_front();
                a = actual(x.dut, x.port);
                total++;
                if (a === x.exp) passed++;
                else $display("FAIL %s dut%0d port%0d: got %h expected %h", x.name, x.dut, x.port, a, x.exp);
            end
        end
    end

    task automatic expect_rd(string name, int dut, int port, logic [31:0] e);
        q.push_back('{name, dut, port, e});
    endtask

    task automatic sample();
        -> go;
        #2;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        we2 = 1'b0; waddr2 = '0; wdata2 = '0; raddr2 = '0;
        #3;
        we = 1'b1; waddr = 5'd5; wdata = 32'h123; raddr = {5'd5, 5'd5};
        expect_rd("rst_bypass_blocked", 0, 0, 32'h0);
        expect_rd("rst_bypass_blocked", 1, 1, 32'h0);
        sample();
        repeat (2) cyc();
        we = 1'b0;
        cyc();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            cyc();
            raddr = {5'(a), 5'(a)};
            raddr2 = {3{4'(a)}};
            for (int p = 0; p < 2; p++) begin
                expect_rd("reset_read", 0, p, 32'h0);
                expect_rd("reset_read", 1, p, 32'h0);
            end
            if (a < 16)
                for (int p = 0; p < 3; p++) expect_rd("reset_read", 2, p, 32'h0);
            sample();
        end

        cyc();
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        cyc();
        we = 1'b0; raddr = {5'd5, 5'd5};
        expect_rd("wr5_high", 0, 0, 32'hDEADBEEF);
        expect_rd("wr5_high", 0, 1, 32'hDEADBEEF);
        expect_rd("wr5_high", 1, 0, 32'hDEADBEEF);
        expect_rd("wr5_high", 1, 1, 32'hDEADBEEF);
        sample();
        @(negedge clk); #1;
        raddr = {5'd6, 5'd5};
        expect_rd("wr5_low", 0, 0, 32'hDEADBEEF);
        expect_rd("addr6_zero", 0, 1, 32'h0);
        expect_rd("wr5_low", 1, 0, 32'hDEADBEEF);
        expect_rd("addr6_zero", 1, 1, 32'h0);
        sample();

        cyc();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        cyc();
        we = 1'b0; raddr = {5'd0, 5'd0};
        expect_rd("zero_reg", 0, 0, 32'h0);
        expect_rd("no_zero_reg", 1, 0, 32'hFFFFFFFF);
        sample();

        cyc();
        we = 1'b1; waddr = 5'd7; wdata = 32'h11;
        cyc();
        wdata = 32'h22; raddr = {5'd7, 5'd7};
        expect_rd("bypass_on", 0, 0, 32'h22);
        expect_rd("bypass_off", 1, 0, 32'h11);
        sample();
        cyc();
        we = 1'b0;
        expect_rd("after_bypass", 0, 1, 32'h22);
        expect_rd("after_bypass", 1, 1, 32'h22);
        sample();

        cyc();
        we = 1'b1; waddr = 5'd0; wdata = 32'h55; raddr = {5'd7, 5'd0};
        expect_rd("zero_over_bypass", 0, 0, 32'h0);
        expect_rd("other_port", 0, 1, 32'h22);
        expect_rd("old_before_edge", 1, 0, 32'hFFFFFFFF);
        sample();
        cyc();
        we = 1'b0;
        expect_rd("zero_after_edge", 0, 0, 32'h0);
        expect_rd("x0_written", 1, 0, 32'h55);
        sample();

        cyc();
        we = 1'b1; waddr = 5'd9; wdata = 32'hAA;
        cyc();
        wdata = 32'hBB;
        cyc();
        we = 1'b0; raddr = {5'd9, 5'd9};
        expect_rd("b2b_last_wins", 0, 0, 32'hBB);
        expect_rd("b2b_last_wins", 1, 1, 32'hBB);
        sample();
        repeat (3) cyc();
        raddr = {5'd5, 5'd9};
        expect_rd("hold_we0", 0, 1, 32'hDEADBEEF);
        expect_rd("hold_we0", 1, 0, 32'hBB);
        sample();

        cyc();
        we = 1'b1; waddr = 5'd3; wdata = 32'hA5;
        cyc();
        we = 1'b0; raddr = {5'd5, 5'd3};
        expect_rd("wr3", 0, 0, 32'hA5);
        sample();
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        expect_rd("async_rst_3", 0, 0, 32'h0);
        expect_rd("async_rst_5", 0, 1, 32'h0);
        expect_rd("async_rst_3", 1, 0, 32'h0);
        expect_rd("async_rst_5", 1, 1, 32'h0);
        sample();
        rst = 1'b0;
        repeat (3) cyc();
        raddr = {5'd0, 5'd3};
        expect_rd("post_rst_3", 0, 0, 32'h0);
        expect_rd("post_rst_3", 1, 0, 32'h0);
        expect_rd("post_rst_0", 1, 1, 32'h0);
        sample();

        cyc();
        we2 = 1'b1; waddr2 = 4'd11; wdata2 = 8'h3C;
        cyc();
        we2 = 1'b0; raddr2 = {4'd11, 4'd11, 4'd11};
        for (int p = 0; p < 3; p++) expect_rd("p8_addr11", 2, p, 32'h3C);
        sample();
        cyc();
        we2 = 1'b1; waddr2 = 4'd13; wdata2 = 8'h77; raddr2 = {4'd11, 4'd13, 4'd13};
        expect_rd("p8_oor_bypass", 2, 0, 32'h0);
        expect_rd("p8_oor_bypass", 2, 1, 32'h0);
        expect_rd("p8_keep11", 2, 2, 32'h3C);
        sample();
        cyc();
        we2 = 1'b0; raddr2 = {4'd14, 4'd13, 4'd5};
        expect_rd("p8_no_alias5", 2, 0, 32'h0);
        expect_rd("p8_read13", 2, 1, 32'h0);
        expect_rd("p8_read14", 2, 2, 32'h0);
        sample();

        for (int k = 0; k < 10 && q.size() > 0; k++) #1;
        if (q.size() > 0) begin
            total++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/latch_regfile.md
Name: latch_regfile

Overview:
- Parametrised register file built on the team's latch-based storage style; successor to the single D_LATCH cell, generalised in width, depth and read-port count.
- Serves as the integer register file of the RV523 datapath: one write port, NREAD combinational read ports, optional hardwired-zero entry 0 (RISC-V x0), optional write-to-read bypass.
- Internally a write-staging register (captured on rising CLK) feeds per-word latches transparent in the CLK-low phase. Externally, behaviour is edge-synchronous write.

Parameters:
WIDTH, 32, data bits per word
DEPTH, 32, number of words (>=2; need not be a power of two)
AW, $clog2(DEPTH), address width (derived; not to be overridden)
NREAD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = word 0 reads as zero and ignores writes
BYPASS, 1, 1 = a read of the address being written this cycle returns WDATA

Ports:
CLK  input  1  single clock; all state changes referenced to rising edge
RST  input  1  asynchronous, active-high reset
WE  input  1  write enable, sampled at rising CLK
WADDR  input  AW  write address
WDATA  input  WIDTH  write data
RADDR  input  NREAD*AW  packed read addresses; port i = bits [i*AW +: AW]
RDATA  output  NREAD*WIDTH  packed read data; port i = bits [i*WIDTH +: WIDTH]

Behaviour:
- Reset: RST high clears every word, the staging register and the staging-valid flag to 0 immediately, without waiting for a clock edge. While RST is high, all RDATA = 0 and writes are ignored. Deassertion is taken synchronously by the first rising edge with RST low.
- Write: at a rising edge with WE=1 and RST=0, staging <= {WADDR, WDATA} and valid <= 1. During the following CLK-low phase the addressed word latch is transparent and captures staging. Write latency is one edge.
- Observable rule: a value written at edge k is returned by a read of that address from edge k until the next write to it. Intermediate latch phases are never visible at RDATA.
- Read: RDATA[i] is purely combinational from RADDR[i] and the array, with no clock latency. All ports are independent, and any number may address the same word.
- Out-of-range addresses (>= DEPTH):
  - A write is dropped and no word changes.
  - A read returns 0.
- ZERO_REG=1: a write to address 0 is dropped and a read of address 0 always returns 0. This takes priority over bypass.
- BYPASS=1: if WE=1, RADDR[i]==WADDR, the address is in range and is not a ZERO_REG-suppressed 0, then RDATA[i]=WDATA in the same cycle, before the edge.
- BYPASS=0: under the same conditions RDATA[i] returns the old stored value until the edge.
- Consecutive writes to the same address on back-to-back edges: the last one wins. No write is lost or reordered.
- WE=0: the array and RDATA hold indefinitely, and CLK toggling has no effect on the contents.
- RST asserted mid-cycle, including during the CLK-low latch phase: the pending staged write is discarded and all words read 0.
- No X may propagate to RDATA from unwritten words; all words are defined from reset.

Test Plan:
- Reset then read: assert RST, release, read all addresses on every port -> RDATA=0 on every port for all 32 addresses.
- Write/read-back: write 0xDEADBEEF to addr 5 at edge k, set RADDR port0=5 and port1=5 -> both return 0xDEADBEEF after edge k; addr 6 still returns 0.
- Zero register: with ZERO_REG=1, write 0xFFFFFFFF to addr 0 -> read addr 0 returns 0; repeat with ZERO_REG=0 -> returns 0xFFFFFFFF.
- Bypass: with addr 7 holding 0x11, drive WE=1, WADDR=7, WDATA=0x22, RADDR=7 before the edge -> RDATA=0x22 with BYPASS=1 and 0x11 with BYPASS=0; both give 0x22 after the edge.
- Async reset mid-operation: write 0xA5 to addr 3 at edge k, pulse RST during the following CLK-low phase -> addr 3 reads 0 immediately and stays 0 after subsequent edges with WE=0.
- Parametrisation: WIDTH=8, DEPTH=12, NREAD=3:
  - Write 0x3C to addr 11 -> all three ports read 0x3C at addr 11.
  - Write to addr 13 is dropped.
  - Read of addr 14 returns 0.
